// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and stage-control outputs for the pipeline stall/flush sequencer.
interface pipeline_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memRead;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             dmem_ready;

    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout;

    // Pipeline side: supplies hazard information, consumes stage controls.
    modport master (
        output id_rs1, id_rs2, ex_rd, ex_memRead, ex_branch_taken, mem_req, dmem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_bubble, stall_cycles, mem_timeout
    );

    // Sequencer side.
    modport slave (
        input  id_rs1, id_rs2, ex_rd, ex_memRead, ex_branch_taken, mem_req, dmem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_bubble, stall_cycles, mem_timeout
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, multi-cycle
// data-memory holds with timeout, and wrong-path squash on taken branches.
// Stage controls are Mealy-decoded in the same cycle; the perf counter and the
// timeout flag are registered.
module pipeline_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned TO_W        = 7,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_stall_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_t;

    localparam logic [TO_W-1:0]  WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_q;
    logic             timeout_q;

    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble;
    logic load_use, issue_decode;

    // Load-use hazard: x0 is never a real dependency.
    assign load_use = bus.ex_memRead && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

    // Next-state and stage-control decode.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        issue_decode  = 1'b0;

        if (reset) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_en      = 1'b0;
            id_ex_flush   = 1'b1;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            state_d       = ST_RUN;
            wait_cnt_d    = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.mem_req && !bus.dmem_ready) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_en     = 1'b0;
                        mem_wb_bubble = 1'b1;
                        state_d       = ST_MEM_WAIT;
                        wait_cnt_d    = TO_W'(1);
                    end else begin
                        issue_decode = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!bus.dmem_ready) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_en     = 1'b0;
                        mem_wb_bubble = 1'b1;
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_d = ST_TIMEOUT;
                        end else begin
                            wait_cnt_d = wait_cnt_q + TO_W'(1);
                        end
                    end else begin
                        // Access completes: MEM advances and held EX hazards apply now.
                        issue_decode = 1'b1;
                        state_d      = ST_RUN;
                        wait_cnt_d   = '0;
                    end
                end
                ST_TIMEOUT: begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                end
                default: begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            endcase

            // Branch squash outranks the load-use bubble: the consumer is wrong-path anyway.
            if (issue_decode) begin
                if (bus.ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    // State, wait counter, saturating stall counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (!pc_en && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (state_d == ST_TIMEOUT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.pc_en         = pc_en;
    assign bus.if_id_en      = if_id_en;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_en      = id_ex_en;
    assign bus.id_ex_flush   = id_ex_flush;
    assign bus.ex_mem_en     = ex_mem_en;
    assign bus.mem_wb_bubble = mem_wb_bubble;
    assign bus.stall_cycles  = stall_q;
    assign bus.mem_timeout   = timeout_q;
endmodule
